// File: rtl/unidade_mul_div_pkg.sv
// pacote_riscv: shared definitions for the RV32M multiply/divide unit.
//   - funct3 codes of the eight M-extension operations
//   - control state encoding (OCIOSO -> CALC -> FIM)
//   - number of radix-2 iterations per operation
package pacote_riscv;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

  localparam int unsigned CICLOS_CALC = 32;

  // All divide/remainder codes have funct3[2] set.
  function automatic logic op_e_divisao(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/unidade_mul_div_divisor.sv
// divisor_restaurador: one combinational step of unsigned restoring division.
//   resto_in  : partial remainder (always < divisor on entry)
//   quoc_in   : dividend bits still to shift in (MSB first), quotient bits
//               accumulate at the LSB end
//   divisor   : divisor magnitude
//   resto_out : updated partial remainder
//   quoc_out  : shifted dividend/quotient word with the new quotient bit
module divisor_restaurador #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] resto_in,
  input  logic [XLEN-1:0] quoc_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] resto_out,
  output logic [XLEN-1:0] quoc_out
);

  logic [XLEN:0] parcial;
  logic [XLEN:0] diferenca;

  // parcial < 2*divisor, so a non-negative difference always fits in XLEN
  // bits and the top bit of the difference is a clean borrow flag.
  always_comb begin
    parcial   = {resto_in, quoc_in[XLEN-1]};
    diferenca = parcial - {1'b0, divisor};
    if (!diferenca[XLEN]) begin
      resto_out = diferenca[XLEN-1:0];
      quoc_out  = {quoc_in[XLEN-2:0], 1'b1};
    end else begin
      resto_out = parcial[XLEN-1:0];
      quoc_out  = {quoc_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unidade_mul_div.sv
// unidade_mul_div: iterative RV32M multiply/divide unit.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : operation request, accepted only when idle
//   funct3       : M-extension operation code
//   read1, read2 : rs1 / rs2 operands from the register bank
//   rd_in        : destination register index
//   busy         : high while an operation is in flight (core stalls)
//   done         : one-cycle result-valid pulse
//   wr           : register bank write enable (done with rd != 0)
//   rd           : destination index of the last result
//   write_data   : last result, held until the next completion
module unidade_mul_div
  import pacote_riscv::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] read1,
  input  logic [XLEN-1:0] read2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wr,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  estado_t           estado;
  logic [5:0]        contador;
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   orig_a;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic              div_ovf;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient word}.
  logic [2*XLEN-1:0] acc;

  logic              sinal_a;
  logic              sinal_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              ovf_in;

  logic [XLEN:0]     soma_mul;
  logic [2*XLEN-1:0] acc_mul;
  logic [XLEN-1:0]   resto_div;
  logic [XLEN-1:0]   quoc_div;

  logic [2*XLEN-1:0] produto;
  logic [XLEN-1:0]   quociente;
  logic [XLEN-1:0]   resto;
  logic [XLEN-1:0]   resultado;

  assign busy = (estado != OCIOSO);

  // Operand sign flags and magnitudes, evaluated on the request inputs.
  always_comb begin
    sinal_a = 1'b0;
    sinal_b = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        sinal_a = read1[XLEN-1];
        sinal_b = read2[XLEN-1];
      end
      F3_MULHSU: sinal_a = read1[XLEN-1];
      default: ;
    endcase
    abs_a  = sinal_a ? -read1 : read1;
    abs_b  = sinal_b ? -read2 : read2;
    ovf_in = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
             (read1 == MIN_NEG) && (read2 == '1);
  end

  // Shift-add multiply step: add the multiplicand when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    soma_mul = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : '0)};
    acc_mul  = {soma_mul, acc[XLEN-1:1]};
  end

  divisor_restaurador #(
    .XLEN(XLEN)
  ) u_divisor (
    .resto_in (acc[2*XLEN-1:XLEN]),
    .quoc_in  (acc[XLEN-1:0]),
    .divisor  (mag_b),
    .resto_out(resto_div),
    .quoc_out (quoc_div)
  );

  // Sign correction and RISC-V special cases.
  always_comb begin
    produto   = neg_res ? -acc : acc;
    quociente = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    resto     = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    resultado = '0;
    case (op)
      F3_MUL:                       resultado = produto[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: resultado = produto[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero)     resultado = '1;
        else if (div_ovf) resultado = MIN_NEG;
        else              resultado = quociente;
      end
      F3_REM, F3_REMU: begin
        if (div_zero)     resultado = orig_a;
        else if (div_ovf) resultado = '0;
        else              resultado = resto;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado     <= OCIOSO;
      contador   <= '0;
      op         <= '0;
      rd_lat     <= '0;
      mag_a      <= '0;
      mag_b      <= '0;
      orig_a     <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      div_ovf    <= 1'b0;
      acc        <= '0;
      done       <= 1'b0;
      wr         <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      done <= 1'b0;
      wr   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (start) begin
            estado   <= CALC;
            contador <= '0;
            op       <= funct3;
            rd_lat   <= rd_in;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            orig_a   <= read1;
            neg_res  <= sinal_a ^ sinal_b;
            neg_rem  <= sinal_a;
            div_zero <= (read2 == '0);
            div_ovf  <= ovf_in;
            acc      <= op_e_divisao(funct3) ? {{XLEN{1'b0}}, abs_a}
                                             : {{XLEN{1'b0}}, abs_b};
          end
        end
        CALC: begin
          contador <= contador + 6'd1;
          // Steps run with contador = 0..31; the cycle at 32 registers the
          // corrected result, so done appears 33 edges after start.
          if (contador == 6'(CICLOS_CALC)) begin
            estado     <= FIM;
            write_data <= resultado;
            rd         <= rd_lat;
            done       <= 1'b1;
            wr         <= (rd_lat != '0);
          end else begin
            acc <= op_e_divisao(op) ? {resto_div, quoc_div} : acc_mul;
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mul_div.sv
module tb_unidade_mul_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] read1;
  logic [31:0] read2;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wr;
  logic [4:0]  rd;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic [31:0] exp;
  } vetor_t;

  vetor_t vetores[$];

  unidade_mul_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .read1(read1), .read2(read2), .rd_in(rd_in),
    .busy(busy), .done(done), .wr(wr), .rd(rd), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] modelo(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'd0: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Accept a request: returns at the negedge just after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; funct3 = f3; read1 = a; read2 = b; rd_in = r;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); read1 = $urandom; read2 = $urandom;
    rd_in = 5'($urandom);
  endtask

  // k counts negedges since the accepting edge (k0 already elapsed).
  task automatic wait_done(input int k0, output int k, output int stray);
    k = k0;
    stray = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (wr && !done) stray++;
    end
  endtask

  task automatic finish_op(input string tag, input int k, input int stray,
                           input logic [31:0] exp, input logic [4:0] r);
    check($sformatf("%s latency", tag), 32'(k), 32'd33);
    check($sformatf("%s data", tag), write_data, exp);
    check($sformatf("%s rd", tag), 32'(rd), 32'(r));
    check($sformatf("%s wr", tag), 32'(wr), 32'(r != 0));
    check($sformatf("%s stray_wr", tag), 32'(stray), 32'd0);
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s wr_pulse", tag), 32'(wr), 32'd0);
    check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    check($sformatf("%s data_hold", tag), write_data, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    int k, stray;
    issue(f3, a, b, r);
    check($sformatf("%s busy", tag), 32'(busy), 32'd1);
    wait_done(0, k, stray);
    finish_op(tag, k, stray, exp, r);
  endtask

  initial begin
    int k, stray, pulses;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  r;

    vetores.push_back('{3'd0, 32'd7,          32'd6,          5'd5,  32'd42});
    vetores.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0});
    vetores.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE});
    vetores.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF});
    vetores.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD});
    vetores.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF});
    vetores.push_back('{3'd5, 32'd100,        32'd7,          5'd7,  32'd14});
    vetores.push_back('{3'd7, 32'd100,        32'd7,          5'd8,  32'd2});
    vetores.push_back('{3'd4, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF});
    vetores.push_back('{3'd6, 32'd5,          32'd0,          5'd10, 32'd5});
    vetores.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000});
    vetores.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h0});
    vetores.push_back('{3'd0, 32'd3,          32'd4,          5'd0,  32'd12});
    vetores.push_back('{3'd5, 32'd9,          32'd0,          5'd13, 32'hFFFF_FFFF});
    vetores.push_back('{3'd7, 32'd9,          32'd0,          5'd14, 32'd9});

    rst = 1'b1; start = 1'b0; funct3 = '0; read1 = '0; read2 = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wr", 32'(wr), 32'd0);
    check("reset rd", 32'(rd), 32'd0);
    check("reset data", write_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vetores.size(); i++)
      run_op($sformatf("vec%0d", i), vetores[i].f3, vetores[i].a, vetores[i].b,
             vetores[i].r, vetores[i].exp);

    // Inputs and a second start while busy must be ignored.
    issue(3'd0, 32'd1234, 32'd5678, 5'd9);
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'd4; read1 = 32'd77; read2 = 32'd3; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, k, stray);
    finish_op("ignore", k, stray, 32'd7006652, 5'd9);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || wr || busy) pulses++;
    end
    check("ignore no_second_op", 32'(pulses), 32'd0);

    // Reset in the middle of CALC aborts with no write.
    issue(3'd0, 32'd100, 32'd3, 5'd17);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort wr", 32'(wr), 32'd0);
    check("abort data", write_data, 32'd0);
    check("abort rd", 32'(rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || wr) pulses++;
    end
    check("abort no_write", 32'(pulses), 32'd0);
    run_op("after_abort", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21,
           modelo(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      r  = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), f3, a, b, r, modelo(f3, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
